switch_port_arbiter: RTL and testbench
======================================

// Module: switch_port_arbiter
// PURPOSE
//  Round-robin scheduler sharing one switch output port between NREQ input queues.
//  - Each requester presents a head-of-queue packet plus a request.
//  - Grants one requester per transfer, with an optional burst hold.
//  - Registers the winning packet into a one-entry output stage.
//  - Drives the port with the valid_op/suspend_op handshake.
//  - Sits between the per-port input FIFOs and the ring injection point (or an output port).
// PARAMETERS
//  NREQ       4   number of requesters (fixed 4 in this release; pointer width 2)
//  DWIDTH     16  packet data width
//  MAX_BURST  2   max consecutive grants to one requester while its req stays high (>=1)
// PORTS
//  clk         in   1            clock, all state on posedge
//  reset       in   1            asynchronous, active-high reset
//  req_i       in   NREQ         request; bit i high = queue i non-empty, head valid on data_i
//  data_i      in   NREQ*DWIDTH  head packets; requester i at [i*DWIDTH +: DWIDTH]
//  gnt_o       out  NREQ         one-hot pop pulse, combinational; queue i pops on this edge
//  valid_op    out  1            output stage holds a packet
//  data_op     out  DWIDTH       packet in output stage
//  src_op      out  2            index of requester that supplied data_op
//  suspend_op  in   1            downstream back-pressure; no transfer while high
//  grant_cnt   out  NREQ*16      per-requester grant counters (see CONFIGURATION)
//  stall_cnt   out  16           cycles with valid_op=1 && suspend_op=1 (see CONFIGURATION)
// BEHAVIOUR
//  Reset values (async, immediate):
//   - valid_op=0, data_op=0, src_op=0; rr_ptr=0; burst_cnt=0; state=EMPTY; counters=0.
//  Transfer rule:
//   - A packet leaves on the posedge where valid_op=1 && suspend_op=0.
//  States:
//   - EMPTY: valid_op=0.
//   - FULL:  valid_op=1.
//  Arbitration enable (arb_en):
//   - arb_en = (state==EMPTY) || (state==FULL && !suspend_op).
//   - Back-to-back packets are allowed; one packet per cycle maximum throughput.
//  Winner selection (when arb_en && |req_i):
//   - If last_src has req high and burst_cnt < MAX_BURST-1: last_src wins (burst hold).
//     (last_src = requester granted most recently.)
//   - Otherwise: first requester with req high, searching rr_ptr, rr_ptr+1, ... mod 4.
//  gnt_o:
//   - Asserted for the winner in the same cycle; all zero when !arb_en or req_i==0.
//  On the grant edge:
//   - data_op <= winner data, src_op <= winner, state=FULL.
//   - If winner==last_src and it was a burst hold: burst_cnt++.
//   - Otherwise: burst_cnt <= 0.
//   - rr_ptr <= winner+1 when the burst ends (burst_cnt reaches MAX_BURST-1 or req drops).
//   - rr_ptr is otherwise unchanged.
//  No grant on a transfer edge: state=EMPTY, valid_op=0 next cycle.
//  Latency: req_i at cycle N with state EMPTY -> valid_op=1 at cycle N+1.
//  Boundary conditions:
//   - suspend_op high: FULL holds data_op/src_op stable, gnt_o=0, no data loss.
//   - Requester's req drops mid-burst: the burst ends immediately and the pointer advances.
//   - MAX_BURST=1: pure round robin.
//   - req_i with X/0 payload is never sampled unless granted.
//   - Reset mid-packet: the output packet is dropped and valid_op=0 at once.
//     Input queues are not popped during reset.
//  Fairness: any requester with req held high is granted within (NREQ-1)*MAX_BURST+1 grants.
// CONFIGURATION
//  SWITCH_ARB_STATS_EN defined:
//   - grant_cnt[i] increments on each grant to i, 16-bit saturating at 16'hFFFF.
//   - stall_cnt increments on each cycle with valid_op && suspend_op, 16-bit saturating.
//   - Both counters clear on reset.
//  SWITCH_ARB_STATS_EN undefined:
//   - No counter logic; grant_cnt and stall_cnt tied to 0.
//   - Port list is unchanged.
// TESTING
//  1 Reset: assert reset mid-FULL -> valid_op=0, gnt_o=0 same cycle.
//    Release; first req_i=4'b0100 -> gnt_o=4'b0100, src_op=2.
//  2 Round robin, MAX_BURST=1, req_i=4'b1111 held, suspend_op=0
//    -> grant order 0,1,2,3,0; one packet per clock.
//  3 Burst, MAX_BURST=2, req_i=4'b1111 held -> grant order 0,0,1,1,2,2,3,3.
//    Drop req_i[1] after its first grant -> next grant is 2.
//  4 Back-pressure: data_op=16'hA5A5 FULL, suspend_op=1 for 5 cycles
//    -> data_op stable, gnt_o=0; stall_cnt=5 with stats on.
//    suspend_op=0 -> transfer, next winner loaded the same edge.
//  5 Idle: req_i=0 after transfer -> valid_op=0 next cycle.
//    req_i=4'b1000 at cycle N -> valid_op=1, data_op=data_i[63:48] at N+1.
//  6 Stats saturation (SWITCH_ARB_STATS_EN): 65540 grants to requester 0
//    -> grant_cnt[15:0]=16'hFFFF; without the macro grant_cnt=0.

Source files
------------

// File: rtl/switch_port_arbiter.sv
// Round-robin scheduler sharing one output port between NREQ input queues, with burst hold.
// Latency: a request seen with the output stage EMPTY gives valid_op=1 on the next cycle.
// Back-pressure: suspend_op freezes the FULL output stage and suppresses all grants.
//
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   req_i, data_i    per-queue request and head packet (queue i at [i*DWIDTH +: DWIDTH])
//   gnt_o            combinational one-hot pop pulse to the winning queue
//   valid_op, data_op, src_op, suspend_op   output stage and downstream handshake
//   grant_cnt, stall_cnt                    statistics counters
// Optional statistics are built only when SWITCH_ARB_STATS_EN is defined;
// otherwise grant_cnt and stall_cnt read as zero.

module switch_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 16,
  parameter int MAX_BURST = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*DWIDTH-1:0]   data_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic                     valid_op,
  output logic [DWIDTH-1:0]        data_op,
  output logic [1:0]               src_op,
  input  logic                     suspend_op,
  output logic [NREQ*16-1:0]       grant_cnt,
  output logic [15:0]              stall_cnt
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_q, state_d;
  logic [1:0]      rr_ptr;
  logic [1:0]      last_src;
  logic            last_vld;   // last_src is meaningful only after the first grant
  logic [BW-1:0]   burst_cnt;

  logic            arb_en;
  logic            grant;
  logic            burst_open;
  logic            hold;
  logic            drop;
  logic [1:0]      base;
  logic [1:0]      winner;
  logic            found;
  logic [1:0]      idx;
  logic [BW-1:0]   next_burst;
  logic            burst_end;
  logic [1:0]      next_ptr;

  always_comb begin
    arb_en     = (state_q == EMPTY) || !suspend_op;
    // A burst is still open while the last winner has hold budget left.
    burst_open = last_vld && (burst_cnt < BURST_LAST);
    hold       = burst_open && req_i[last_src];
    // The burst owner went idle mid-burst: skip past it rather than the stale pointer.
    drop       = burst_open && !req_i[last_src];
    base       = drop ? (last_src + 2'd1) : rr_ptr;

    winner = base;
    found  = 1'b0;
    idx    = base;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && req_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    if (hold) winner = last_src;

    // Queues must not pop while reset is held.
    grant = arb_en && (|req_i) && !reset;
    gnt_o = grant ? (NREQ'(1) << winner) : '0;

    next_burst = hold ? (burst_cnt + BW'(1)) : '0;
    burst_end  = (next_burst == BURST_LAST);
    next_ptr   = burst_end ? (winner + 2'd1) : (drop ? (last_src + 2'd1) : rr_ptr);

    state_d = state_q;
    if (grant)                                 state_d = FULL;
    else if (state_q == FULL && !suspend_op)   state_d = EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      data_op   <= '0;
      src_op    <= '0;
      rr_ptr    <= '0;
      last_src  <= '0;
      last_vld  <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        data_op   <= data_i[32'(winner)*DWIDTH +: DWIDTH];
        src_op    <= winner;
        last_src  <= winner;
        last_vld  <= 1'b1;
        burst_cnt <= next_burst;
        rr_ptr    <= next_ptr;
      end
    end
  end

  assign valid_op = (state_q == FULL);

`ifdef SWITCH_ARB_STATS_EN
  logic [15:0] gcnt [NREQ];
  logic [15:0] scnt;

  for (genvar g = 0; g < NREQ; g++) begin : g_gcnt
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                                gcnt[g] <= '0;
      else if (gnt_o[g] && gcnt[g] != 16'hFFFF) gcnt[g] <= gcnt[g] + 16'd1;
    end
    assign grant_cnt[g*16 +: 16] = gcnt[g];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         scnt <= '0;
    else if (valid_op && suspend_op && scnt != 16'hFFFF) scnt <= scnt + 16'd1;
  end
  assign stall_cnt = scnt;
`else
  assign grant_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Directed bench: one round-robin instance (MAX_BURST=1) and one burst instance
// (MAX_BURST=2) share the same stimulus; expected values are hand-derived.
module tb_switch_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_i;
  logic [63:0] data_i;
  logic        suspend_op;

  logic [3:0]  gnt_b, gnt_r;
  logic        vld_b, vld_r;
  logic [15:0] dat_b, dat_r;
  logic [1:0]  src_b, src_r;
  logic [63:0] gcnt_b, gcnt_r;
  logic [15:0] scnt_b, scnt_r;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  switch_port_arbiter #(.NREQ(4), .DWIDTH(16), .MAX_BURST(2)) u_burst (
    .clk(clk), .reset(reset), .req_i(req_i), .data_i(data_i), .gnt_o(gnt_b),
    .valid_op(vld_b), .data_op(dat_b), .src_op(src_b), .suspend_op(suspend_op),
    .grant_cnt(gcnt_b), .stall_cnt(scnt_b));

  switch_port_arbiter #(.NREQ(4), .DWIDTH(16), .MAX_BURST(1)) u_rr (
    .clk(clk), .reset(reset), .req_i(req_i), .data_i(data_i), .gnt_o(gnt_r),
    .valid_op(vld_r), .data_op(dat_r), .src_op(src_r), .suspend_op(suspend_op),
    .grant_cnt(gcnt_r), .stall_cnt(scnt_r));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_i = '0;
    suspend_op = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int exp_r[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_b[13] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 2, 2};

  initial begin
    data_i = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    do_reset();
    #1;
    chk("rst_valid", 64'(vld_b), 64'd0);
    chk("rst_data",  64'(dat_b), 64'd0);
    chk("rst_src",   64'(src_b), 64'd0);
    chk("rst_gnt",   64'(gnt_b), 64'd0);

    // 1: reset while FULL, then first request after release
    tick();
    req_i = 4'b0001;
    tick();
    req_i = 4'b0010;
    suspend_op = 1'b1;
    #1;
    chk("full_before_rst", 64'(vld_b), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(vld_b), 64'd0);
    chk("rst_mid_gnt",   64'(gnt_b), 64'd0);
    tick();
    reset = 1'b0;
    suspend_op = 1'b0;
    req_i = 4'b0100;
    #1;
    chk("first_gnt", 64'(gnt_b), 64'b0100);
    tick();
    chk("first_src",  64'(src_b), 64'd2);
    chk("first_data", 64'(dat_b), 64'hD002);
    chk("first_vld",  64'(vld_b), 64'd1);

    // 2 and 3: all requesting, round robin vs burst of two
    do_reset();
    req_i = 4'b1111;
    for (int k = 0; k < 13; k++) begin
      if (k == 11) req_i = 4'b1101;
      #1;
      if (k < 8) chk($sformatf("rr_gnt%0d", k), 64'(gnt_r), 64'(4'b0001 << exp_r[k]));
      chk($sformatf("burst_gnt%0d", k), 64'(gnt_b), 64'(4'b0001 << exp_b[k]));
      if (k > 0 && k < 8) begin
        chk($sformatf("rr_src%0d", k), 64'(src_r), 64'(exp_r[k-1]));
        chk($sformatf("rr_vld%0d", k), 64'(vld_r), 64'd1);
      end
      tick();
    end

    // 4: back-pressure holds the output stage
    do_reset();
    data_i[15:0] = 16'hA5A5;
    req_i = 4'b0001;
    tick();
    req_i = 4'b0010;
    suspend_op = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_gnt%0d", k),  64'(gnt_b), 64'd0);
      chk($sformatf("bp_data%0d", k), 64'(dat_b), 64'hA5A5);
      chk($sformatf("bp_vld%0d", k),  64'(vld_b), 64'd1);
      @(posedge clk);
    end
    #1;
    suspend_op = 1'b0;
    #1;
`ifdef SWITCH_ARB_STATS_EN
    chk("stall_cnt", 64'(scnt_b), 64'd5);
`else
    chk("stall_cnt", 64'(scnt_b), 64'd0);
`endif
    chk("bp_release_gnt", 64'(gnt_b), 64'b0010);
    tick();
    chk("bp_next_data", 64'(dat_b), 64'hD001);
    chk("bp_next_src",  64'(src_b), 64'd1);

    // 5: idle then single request from queue 3
    req_i = 4'b0000;
    tick();
    chk("idle_vld", 64'(vld_b), 64'd0);
    req_i = 4'b1000;
    #1;
    chk("idle_gnt", 64'(gnt_b), 64'b1000);
    tick();
    chk("lat_vld",  64'(vld_b), 64'd1);
    chk("lat_data", 64'(dat_b), 64'hD003);
    chk("lat_src",  64'(src_b), 64'd3);

    // 6: grant counter saturation
`ifdef SWITCH_ARB_STATS_EN
    do_reset();
    req_i = 4'b0001;
    repeat (65540) tick();
    chk("gcnt_sat", 64'(gcnt_b[15:0]), 64'hFFFF);
    chk("gcnt_other", 64'(gcnt_b[63:16]), 64'd0);
`else
    chk("gcnt_zero", gcnt_b, 64'd0);
    chk("gcnt_zero_rr", gcnt_r, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
